buffer_arbiter: RTL

- Arbitrates two requesters (A, B) onto one shared 8-bit push/pop buffer (stack or queue mode) and sequences that buffer's controls.
- Drives the buffer's write/read strobes, mode selects and synchronous reset, and tracks occupancy itself, because the buffer exports no status.
- Returns read data and completion/error acknowledges to the winning requester.

---
 rtl/buffer_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/buffer_arbiter.sv
// buffer_arbiter: two-requester arbiter in front of a shared 8-bit push/pop
// buffer (stack or queue). It sequences the buffer strobes, mode selects and
// synchronous reset. It also tracks occupancy, because the buffer has no status
// outputs.
// Build option: define ARB_FIXED_PRIO_EN to make A win every tie. The default
// build uses round-robin with a last-grant pointer.
module buffer_arbiter #(
  parameter int DEPTH = 7,
  parameter int DW    = 8,
  parameter int CW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_mode,
  input  logic          i_flush,
  input  logic          i_req_a,
  input  logic          i_req_b,
  input  logic          i_op_a,
  input  logic          i_op_b,
  input  logic [DW-1:0] i_din_a,
  input  logic [DW-1:0] i_din_b,
  output logic          o_ack_a,
  output logic          o_ack_b,
  output logic          o_err,
  output logic [DW-1:0] o_dout,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_buf_rst,
  output logic          o_buf_wrn,
  output logic          o_buf_ren,
  output logic          o_buf_lifo,
  output logic          o_buf_fifo,
  output logic [DW-1:0] o_buf_in,
  input  logic [DW-1:0] i_buf_out
);

  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_ISSUE, S_CAPT, S_DONE} state_t;

  state_t        r_state;
  logic          r_op;      // 1 = read
  logic          r_gnt_b;   // 1 = B holds the current grant
  logic          r_ack_a;
  logic          r_ack_b;
  logic          r_err;
  logic          r_lifo;    // active buffer mode
  logic [DW-1:0] r_dout;
  logic [DW-1:0] r_buf_in;
  logic [CW-1:0] r_count;

  logic          w_win_b;
  logic          w_op;
  logic          w_full;
  logic          w_empty;
  logic          w_reject;

`ifdef ARB_FIXED_PRIO_EN
  // A always wins a tie.
  assign w_win_b = i_req_b & ~i_req_a;
`else
  logic r_last_b;   // last grant went to B; the reset value lets A win the first tie

  // On a tie, grant the requester that was not granted last.
  assign w_win_b = i_req_b & (~i_req_a | ~r_last_b);

  // Move the last-grant pointer on every acknowledge, including errors.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                r_last_b <= 1'b1;
    else if (r_state == S_DONE)  r_last_b <= r_gnt_b;
  end
`endif

  assign w_op     = w_win_b ? i_op_b : i_op_a;
  assign w_full   = (r_count == LP_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_reject = w_op ? w_empty : w_full;

  // Main sequencer. ACK and ERR are registered and are set on the edge that
  // enters DONE, so they are high exactly during the DONE cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_FLUSH;
      r_op     <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_ack_a  <= 1'b0;
      r_ack_b  <= 1'b0;
      r_err    <= 1'b0;
      r_lifo   <= 1'b0;
      r_dout   <= '0;
      r_buf_in <= '0;
      r_count  <= '0;
    end else begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_FLUSH: begin
          r_count <= '0;
          r_lifo  <= i_mode;
          r_state <= S_IDLE;
        end
        S_IDLE: begin
          // A mode change waits until the buffer is empty, so the stored data
          // is never reinterpreted in the other mode.
          if (w_empty) r_lifo <= i_mode;
          if (i_flush) begin
            r_state <= S_FLUSH;
          end else if (i_req_a | i_req_b) begin
            r_gnt_b  <= w_win_b;
            r_op     <= w_op;
            r_buf_in <= w_win_b ? i_din_b : i_din_a;
            if (w_reject) begin
              r_state <= S_DONE;
              r_ack_a <= ~w_win_b;
              r_ack_b <= w_win_b;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (r_op) begin
            r_count <= r_count - 1'b1;
            r_state <= S_CAPT;
          end else begin
            r_count <= r_count + 1'b1;
            r_state <= S_DONE;
            r_ack_a <= ~r_gnt_b;
            r_ack_b <= r_gnt_b;
          end
        end
        S_CAPT: begin
          r_dout  <= i_buf_out;
          r_state <= S_DONE;
          r_ack_a <= ~r_gnt_b;
          r_ack_b <= r_gnt_b;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_FLUSH;
      endcase
    end
  end

  // The strobes are decoded from the state, so at most one can be high.
  assign o_buf_rst  = (r_state == S_FLUSH);
  assign o_buf_wrn  = (r_state == S_ISSUE) & ~r_op;
  assign o_buf_ren  = (r_state == S_ISSUE) &  r_op;
  assign o_buf_lifo = r_lifo;
  assign o_buf_fifo = ~r_lifo;
  assign o_buf_in   = r_buf_in;

  assign o_ack_a    = r_ack_a;
  assign o_ack_b    = r_ack_b;
  assign o_err      = r_err;
  assign o_dout     = r_dout;
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;

endmodule
